layer_compositor_ctrl: RTL and testbench

// - Per-pixel layer arbiter and palette scheduler in front of the VGA output.
// - Takes per-pixel hit flags from the sprite/object generators (coin, score, board, ground, ...).
// - Applies a per-frame enable mask, picks the highest-priority layer and emits registered RGB.
// - Palette/enable config is written any time and takes effect only at frame boundaries (no tearing).

---
 rtl/layer_compositor_ctrl_if.sv | 31 +++
 rtl/layer_compositor_ctrl.sv | 139 +++++++++++++
 tb/tb_layer_compositor_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/layer_compositor_ctrl_if.sv
// Pixel/config bundle between the object generators, config master and the compositor.
`default_nettype none

interface layer_compositor_ctrl_if #(
    parameter int NUM_LAYERS = 4
);
    logic                  frame_start;
    logic                  pix_valid;
    logic [NUM_LAYERS-1:0] layer_req;
    logic                  cfg_we;
    logic [2:0]            cfg_addr;
    logic [23:0]           cfg_wdata;
    logic                  out_valid;
    logic [2:0]            out_layer;
    logic [7:0]            VGA_R;
    logic [7:0]            VGA_G;
    logic [7:0]            VGA_B;
    logic                  blink_phase;

    modport master (
        output frame_start, pix_valid, layer_req, cfg_we, cfg_addr, cfg_wdata,
        input  out_valid, out_layer, VGA_R, VGA_G, VGA_B, blink_phase
    );

    modport slave (
        input  frame_start, pix_valid, layer_req, cfg_we, cfg_addr, cfg_wdata,
        output out_valid, out_layer, VGA_R, VGA_G, VGA_B, blink_phase
    );
endinterface

`default_nettype wire

// File: rtl/layer_compositor_ctrl.sv
// layer_compositor_ctrl: per-pixel layer arbiter with frame-synchronous palette.
// Optional blink support is enabled by defining LAYER_BLINK_EN.  Rev 1.0
`default_nettype none

module layer_compositor_ctrl #(
    parameter int NUM_LAYERS   = 4,
    parameter int BLINK_FRAMES = 16
) (
    input wire Clk,
    input wire Reset,
    layer_compositor_ctrl_if.slave bus
);
    localparam logic [23:0] c_BG = 24'hFFFFFF;
    localparam logic [2:0]  c_BG_IDX = 3'(NUM_LAYERS);
    localparam logic [23:0] c_RST_COL [6] = '{24'hFFFF00, 24'h87CEEB, 24'hF0828C,
                                              24'h000000, 24'h000000, 24'h000000};

    logic [23:0]           col_sh_q  [NUM_LAYERS];
    logic [23:0]           col_act_q [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] en_sh_q, en_act_q;
    logic [NUM_LAYERS-1:0] w_blk_mask;
    logic                  w_phase;

`ifdef LAYER_BLINK_EN
    localparam int              c_CW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CW-1:0] c_MAX = c_CW'(BLINK_FRAMES - 1);

    logic [NUM_LAYERS-1:0] blink_sh_q, blink_act_q;
    logic [c_CW-1:0]       frm_cnt_q;
    logic                  phase_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            blink_sh_q  <= '0;
            blink_act_q <= '0;
            frm_cnt_q   <= '0;
            phase_q     <= 1'b0;
        end else begin
            if (bus.cfg_we && bus.cfg_addr == 3'd6)
                blink_sh_q <= bus.cfg_wdata[NUM_LAYERS-1:0];
            if (bus.frame_start) begin
                blink_act_q <= blink_sh_q;
                if (frm_cnt_q == c_MAX) begin
                    frm_cnt_q <= '0;
                    phase_q   <= ~phase_q;
                end else begin
                    frm_cnt_q <= frm_cnt_q + 1'b1;
                end
            end
        end
    end

    assign w_phase    = phase_q;
    assign w_blk_mask = phase_q ? blink_act_q : '0;
`else
    assign w_phase    = 1'b0;
    assign w_blk_mask = '0;
`endif

    // Shadow takes writes; active copies the pre-write shadow only at frame_start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                col_sh_q[i]  <= c_RST_COL[i];
                col_act_q[i] <= c_RST_COL[i];
            end
            en_sh_q  <= '1;
            en_act_q <= '1;
        end else begin
            if (bus.cfg_we) begin
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    if (bus.cfg_addr == 3'(i))
                        col_sh_q[i] <= bus.cfg_wdata;
                end
                if (bus.cfg_addr == 3'd7)
                    en_sh_q <= bus.cfg_wdata[NUM_LAYERS-1:0];
            end
            if (bus.frame_start) begin
                for (int i = 0; i < NUM_LAYERS; i++)
                    col_act_q[i] <= col_sh_q[i];
                en_act_q <= en_sh_q;
            end
        end
    end

    logic                  s1_valid_q;
    logic [NUM_LAYERS-1:0] s1_req_q, s1_req_d;
    logic                  out_valid_q;
    logic [2:0]            out_layer_q, out_layer_d;
    logic [23:0]           rgb_q, rgb_d;

    always_comb begin
        s1_req_d = '0;
        if (bus.pix_valid)
            s1_req_d = bus.layer_req & en_act_q & ~w_blk_mask;
    end

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        out_layer_d = c_BG_IDX;
        rgb_d       = c_BG;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_req_q[i]) begin
                out_layer_d = 3'(i);
                rgb_d       = col_act_q[i];
            end
        end
        if (!s1_valid_q) begin
            out_layer_d = c_BG_IDX;
            rgb_d       = 24'h000000;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s1_req_q    <= '0;
            out_valid_q <= 1'b0;
            out_layer_q <= c_BG_IDX;
            rgb_q       <= 24'h000000;
        end else begin
            s1_valid_q  <= bus.pix_valid;
            s1_req_q    <= s1_req_d;
            out_valid_q <= s1_valid_q;
            out_layer_q <= out_layer_d;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_layer   = out_layer_q;
    assign bus.VGA_R       = rgb_q[23:16];
    assign bus.VGA_G       = rgb_q[15:8];
    assign bus.VGA_B       = rgb_q[7:0];
    assign bus.blink_phase = w_phase;

endmodule

`default_nettype wire

// File: tb/tb_layer_compositor_ctrl.sv
// Directed self-checking bench for layer_compositor_ctrl (both LAYER_BLINK_EN builds).
`default_nettype none

module tb_layer_compositor_ctrl;
    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    layer_compositor_ctrl_if #(.NUM_LAYERS(4)) bus ();

    layer_compositor_ctrl #(.NUM_LAYERS(4), .BLINK_FRAMES(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] lay, input logic [23:0] rgb);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, "_layer"}, 32'(bus.out_layer), 32'(lay));
        check({tag, "_rgb"}, 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'(rgb));
    endtask

    // One isolated pixel; outputs are sampled two edges after it is presented.
    task automatic pixel(input logic [3:0] req);
        bus.pix_valid = 1'b1;
        bus.layer_req = req;
        tick();
        bus.pix_valid = 1'b0;
        bus.layer_req = 4'b0000;
        tick();
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [23:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        Reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.layer_req   = 4'b0000;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = 3'd0;
        bus.cfg_wdata   = 24'h0;
        tick();
        tick();
        chk_out("reset", 1'b0, 3'd4, 24'h000000);
        check("reset_phase", 32'(bus.blink_phase), 32'd0);
        Reset = 1'b0;
        tick();

        pixel(4'b0110);
        chk_out("prio_0110", 1'b1, 3'd1, 24'h87CEEB);
        pixel(4'b1100);
        chk_out("prio_1100", 1'b1, 3'd2, 24'hF0828C);
        pixel(4'b1000);
        chk_out("prio_1000", 1'b1, 3'd3, 24'h000000);
        pixel(4'b0000);
        chk_out("bg", 1'b1, 3'd4, 24'hFFFFFF);

        bus.layer_req = 4'b1111;
        tick();
        tick();
        chk_out("blank", 1'b0, 3'd4, 24'h000000);
        bus.layer_req = 4'b0000;

        cfg_write(3'd0, 24'h123456);
        pixel(4'b0001);
        chk_out("shadow_pre", 1'b1, 3'd0, 24'hFFFF00);
        frame();
        pixel(4'b0001);
        chk_out("shadow_post", 1'b1, 3'd0, 24'h123456);

        bus.cfg_we      = 1'b1;
        bus.cfg_addr    = 3'd0;
        bus.cfg_wdata   = 24'hABCDEF;
        bus.frame_start = 1'b1;
        tick();
        bus.cfg_we      = 1'b0;
        bus.frame_start = 1'b0;
        pixel(4'b0001);
        chk_out("coinc_1st", 1'b1, 3'd0, 24'h123456);
        frame();
        pixel(4'b0001);
        chk_out("coinc_2nd", 1'b1, 3'd0, 24'hABCDEF);

        cfg_write(3'd4, 24'h00FF00);
        cfg_write(3'd5, 24'h00FF00);
        cfg_write(3'd7, 24'h00000E);
        pixel(4'b0001);
        chk_out("en_pre", 1'b1, 3'd0, 24'hABCDEF);
        frame();
        pixel(4'b0011);
        chk_out("en_0011", 1'b1, 3'd1, 24'h87CEEB);
        pixel(4'b0001);
        chk_out("en_0001", 1'b1, 3'd4, 24'hFFFFFF);

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        cfg_write(3'd6, 24'h000001);
        for (int i = 0; i < 15; i++) frame();
        check("blink_15_phase", 32'(bus.blink_phase), 32'd0);
        pixel(4'b0001);
        chk_out("blink_15", 1'b1, 3'd0, 24'hFFFF00);
        frame();
`ifdef LAYER_BLINK_EN
        check("blink_16_phase", 32'(bus.blink_phase), 32'd1);
        pixel(4'b0001);
        chk_out("blink_16", 1'b1, 3'd4, 24'hFFFFFF);
        pixel(4'b0011);
        chk_out("blink_16_l1", 1'b1, 3'd1, 24'h87CEEB);
`else
        check("blink_16_phase", 32'(bus.blink_phase), 32'd0);
        pixel(4'b0001);
        chk_out("blink_16", 1'b1, 3'd0, 24'hFFFF00);
`endif
        for (int i = 0; i < 16; i++) frame();
        check("blink_32_phase", 32'(bus.blink_phase), 32'd0);
        pixel(4'b0001);
        chk_out("blink_32", 1'b1, 3'd0, 24'hFFFF00);

        cfg_write(3'd0, 24'h111111);
        frame();
        pixel(4'b0001);
        chk_out("pre_rst", 1'b1, 3'd0, 24'h111111);
        bus.pix_valid = 1'b1;
        bus.layer_req = 4'b0001;
        tick();
        bus.layer_req   = 4'b0010;
        Reset           = 1'b1;
        bus.cfg_we      = 1'b1;
        bus.cfg_addr    = 3'd0;
        bus.cfg_wdata   = 24'h222222;
        bus.frame_start = 1'b1;
        tick();
        check("rst_c0_valid", 32'(bus.out_valid), 32'd0);
        Reset           = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.frame_start = 1'b0;
        bus.layer_req   = 4'b0001;
        tick();
        check("rst_c1_valid", 32'(bus.out_valid), 32'd0);
        bus.layer_req = 4'b0010;
        tick();
        chk_out("rst_c2", 1'b1, 3'd0, 24'hFFFF00);
        bus.pix_valid = 1'b0;
        bus.layer_req = 4'b0000;
        tick();
        chk_out("rst_c3", 1'b1, 3'd1, 24'h87CEEB);
        check("rst_phase", 32'(bus.blink_phase), 32'd0);
        frame();
        pixel(4'b0001);
        chk_out("rst_shadow", 1'b1, 3'd0, 24'hFFFF00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
